// File: rtl/rbus_xbarnxm.sv
// rbus N-input/M-output packet crossbar: per-input store-and-forward FIFOs, header routing.
// Define RBUS_XBAR_RR_EN for round-robin output arbitration; otherwise the lowest eligible input wins.
module rbus_xbarnxm #(
    parameter int N       = 3,
    parameter int M       = 2,
    parameter int DEPTH   = 32,
    parameter int DST_LSB = 56,
    parameter int LEN_LSB = 60,
    parameter int CLS_BIT = 70
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stb  [0:N-1],
    input  logic        i_sof  [0:N-1],
    input  logic [71:0] i_data [0:N-1],
    output logic [1:0]  i_rdy  [0:N-1],
    output logic [1:0]  i_rdyE [0:N-1],
    output logic        o_stb  [0:M-1],
    output logic        o_sof  [0:M-1],
    output logic [71:0] o_data [0:M-1],
    input  logic [1:0]  o_rdy  [0:M-1],
    input  logic [1:0]  o_rdyE [0:M-1],
    output logic        ff_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    // One bit wider than clog2(M) so out-of-range destinations are detectable.
    localparam int DST_W = $clog2(M) + 1;
    localparam logic [PW-1:0]    FULL  = PW'(DEPTH);
    localparam logic [PW-1:0]    SPACE = PW'(DEPTH - 16);
    localparam logic [DST_W-1:0] M_LIM = DST_W'(M);

    typedef enum logic {IDLE, SEND} state_t;

    logic [71:0]   mem_q [0:N-1][0:DEPTH-1];
    logic [PW-1:0] wr_ptr_q [0:N-1], wr_ptr_d [0:N-1];
    logic [PW-1:0] commit_ptr_q [0:N-1], commit_ptr_d [0:N-1];
    logic [PW-1:0] rd_ptr_q [0:N-1], rd_ptr_d [0:N-1];
    logic [3:0]    rem_q [0:N-1], rem_d [0:N-1];
    logic          open_q [0:N-1], open_d [0:N-1];
    logic          drop_q [0:N-1], drop_d [0:N-1];
    logic          we [0:N-1];
    logic [AW-1:0] waddr [0:N-1];
    logic          err_q, err_d;
    logic [PW-1:0] used [0:N-1];

    logic [71:0]   head [0:N-1];
    logic          busy [0:N-1];
    logic [N-1:0]  elig [0:M-1];
    logic          found [0:M-1];
    logic [GW-1:0] pick [0:M-1];

    state_t        state_q [0:M-1], state_d [0:M-1];
    logic [GW-1:0] grant_q [0:M-1], grant_d [0:M-1];
    logic [3:0]    len_q [0:M-1], len_d [0:M-1];
    logic [3:0]    cnt_q [0:M-1], cnt_d [0:M-1];
    logic          o_stb_q [0:M-1], o_stb_d [0:M-1];
    logic          o_sof_q [0:M-1], o_sof_d [0:M-1];
    logic [71:0]   o_data_q [0:M-1], o_data_d [0:M-1];
`ifdef RBUS_XBAR_RR_EN
    logic [GW-1:0] rr_q [0:M-1], rr_d [0:M-1];
`endif

    assign o_stb  = o_stb_q;
    assign o_sof  = o_sof_q;
    assign o_data = o_data_q;
    assign ff_err = err_q;

    always_comb begin
        for (int unsigned n = 0; n < N; n++) begin
            used[n]   = wr_ptr_q[n] - rd_ptr_q[n];
            i_rdy[n]  = (used[n] <= SPACE) ? 2'b11 : 2'b00;
            i_rdyE[n] = (wr_ptr_q[n] == rd_ptr_q[n]) ? 2'b11 : 2'b00;
        end
    end

    // Input writers; a header always lands at commit_ptr, which also rolls back an open packet.
    always_comb begin
        err_d = err_q;
        for (int unsigned n = 0; n < N; n++) begin
            wr_ptr_d[n]     = wr_ptr_q[n];
            commit_ptr_d[n] = commit_ptr_q[n];
            rem_d[n]        = rem_q[n];
            open_d[n]       = open_q[n];
            drop_d[n]       = drop_q[n];
            we[n]           = 1'b0;
            waddr[n]        = wr_ptr_q[n][AW-1:0];
            if (i_stb[n] && i_sof[n]) begin
                if (open_q[n]) err_d = 1'b1;
                wr_ptr_d[n] = commit_ptr_q[n];
                open_d[n]   = 1'b0;
                drop_d[n]   = 1'b0;
                if (i_data[n][DST_LSB +: DST_W] >= M_LIM) begin
                    err_d     = 1'b1;
                    drop_d[n] = (i_data[n][LEN_LSB +: 4] != 4'd0);
                    rem_d[n]  = i_data[n][LEN_LSB +: 4];
                end else if (commit_ptr_q[n] - rd_ptr_q[n] == FULL) begin
                    err_d = 1'b1;
                end else begin
                    we[n]       = 1'b1;
                    waddr[n]    = commit_ptr_q[n][AW-1:0];
                    wr_ptr_d[n] = commit_ptr_q[n] + PW'(1);
                    if (i_data[n][LEN_LSB +: 4] == 4'd0) begin
                        commit_ptr_d[n] = commit_ptr_q[n] + PW'(1);
                    end else begin
                        open_d[n] = 1'b1;
                        rem_d[n]  = i_data[n][LEN_LSB +: 4];
                    end
                end
            end else if (i_stb[n]) begin
                if (open_q[n]) begin
                    if (used[n] == FULL) begin
                        err_d       = 1'b1;
                        wr_ptr_d[n] = commit_ptr_q[n];
                        open_d[n]   = 1'b0;
                    end else begin
                        we[n]       = 1'b1;
                        wr_ptr_d[n] = wr_ptr_q[n] + PW'(1);
                        rem_d[n]    = rem_q[n] - 4'd1;
                        if (rem_q[n] == 4'd1) begin
                            commit_ptr_d[n] = wr_ptr_q[n] + PW'(1);
                            open_d[n]       = 1'b0;
                        end
                    end
                end else if (drop_q[n]) begin
                    rem_d[n]  = rem_q[n] - 4'd1;
                    drop_d[n] = (rem_q[n] != 4'd1);
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // Eligibility and arbitration; a lane being read by any output is excluded.
    always_comb begin
        int unsigned idx;
        idx = 0;
        for (int unsigned n = 0; n < N; n++) begin
            head[n] = mem_q[n][rd_ptr_q[n][AW-1:0]];
            busy[n] = 1'b0;
            for (int unsigned m = 0; m < M; m++)
                if (state_q[m] == SEND && grant_q[m] == GW'(n)) busy[n] = 1'b1;
        end
        for (int unsigned m = 0; m < M; m++) begin
            found[m] = 1'b0;
            pick[m]  = '0;
            for (int unsigned n = 0; n < N; n++)
                elig[m][n] = !busy[n] && (rd_ptr_q[n] != commit_ptr_q[n]) &&
                             (head[n][DST_LSB +: DST_W] == DST_W'(m)) &&
                             (o_rdy[m][head[n][CLS_BIT]] | o_rdyE[m][head[n][CLS_BIT]]);
            for (int unsigned k = 0; k < N; k++) begin
`ifdef RBUS_XBAR_RR_EN
                idx = (32'(rr_q[m]) + k) % N;
`else
                idx = k;
`endif
                if (!found[m] && elig[m][idx]) begin
                    found[m] = 1'b1;
                    pick[m]  = GW'(idx);
                end
            end
        end
    end

    always_comb begin
        for (int unsigned m = 0; m < M; m++) begin
            state_d[m] = state_q[m];
            grant_d[m] = grant_q[m];
            len_d[m]   = len_q[m];
            cnt_d[m]   = cnt_q[m];
`ifdef RBUS_XBAR_RR_EN
            rr_d[m]    = rr_q[m];
`endif
            case (state_q[m])
                IDLE: if (found[m]) begin
                    state_d[m] = SEND;
                    grant_d[m] = pick[m];
                    cnt_d[m]   = 4'd0;
                    len_d[m]   = 4'd0;
                    for (int unsigned n = 0; n < N; n++)
                        if (pick[m] == GW'(n)) len_d[m] = head[n][LEN_LSB +: 4];
`ifdef RBUS_XBAR_RR_EN
                    rr_d[m] = (32'(pick[m]) == N - 1) ? '0 : pick[m] + GW'(1);
`endif
                end
                SEND: begin
                    cnt_d[m] = cnt_q[m] + 4'd1;
                    if (cnt_q[m] == len_q[m]) state_d[m] = IDLE;
                end
                default: state_d[m] = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int unsigned n = 0; n < N; n++) rd_ptr_d[n] = rd_ptr_q[n];
        for (int unsigned m = 0; m < M; m++) begin
            o_stb_d[m]  = 1'b0;
            o_sof_d[m]  = 1'b0;
            o_data_d[m] = '0;
            if (state_q[m] == SEND) begin
                o_stb_d[m] = 1'b1;
                o_sof_d[m] = (cnt_q[m] == 4'd0);
                for (int unsigned n = 0; n < N; n++)
                    if (grant_q[m] == GW'(n)) begin
                        o_data_d[m] = head[n];
                        rd_ptr_d[n] = rd_ptr_q[n] + PW'(1);
                    end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned n = 0; n < N; n++)
            if (we[n]) mem_q[n][waddr[n]] <= i_data[n];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            for (int unsigned n = 0; n < N; n++) begin
                wr_ptr_q[n]     <= '0;
                commit_ptr_q[n] <= '0;
                rd_ptr_q[n]     <= '0;
                rem_q[n]        <= '0;
                open_q[n]       <= 1'b0;
                drop_q[n]       <= 1'b0;
            end
            for (int unsigned m = 0; m < M; m++) begin
                state_q[m]  <= IDLE;
                grant_q[m]  <= '0;
                len_q[m]    <= '0;
                cnt_q[m]    <= '0;
                o_stb_q[m]  <= 1'b0;
                o_sof_q[m]  <= 1'b0;
                o_data_q[m] <= '0;
`ifdef RBUS_XBAR_RR_EN
                rr_q[m]     <= '0;
`endif
            end
        end else begin
            err_q <= err_d;
            for (int unsigned n = 0; n < N; n++) begin
                wr_ptr_q[n]     <= wr_ptr_d[n];
                commit_ptr_q[n] <= commit_ptr_d[n];
                rd_ptr_q[n]     <= rd_ptr_d[n];
                rem_q[n]        <= rem_d[n];
                open_q[n]       <= open_d[n];
                drop_q[n]       <= drop_d[n];
            end
            for (int unsigned m = 0; m < M; m++) begin
                state_q[m]  <= state_d[m];
                grant_q[m]  <= grant_d[m];
                len_q[m]    <= len_d[m];
                cnt_q[m]    <= cnt_d[m];
                o_stb_q[m]  <= o_stb_d[m];
                o_sof_q[m]  <= o_sof_d[m];
                o_data_q[m] <= o_data_d[m];
`ifdef RBUS_XBAR_RR_EN
                rr_q[m]     <= rr_d[m];
`endif
            end
        end
    end

endmodule

// File: tb/tb_rbus_xbarnxm.sv
// Directed bench for rbus_xbarnxm: per-cycle vector table plus hand-written corner sequences.
module tb_rbus_xbarnxm;
    localparam int N = 3;
    localparam int M = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_stb  [0:N-1];
    logic        i_sof  [0:N-1];
    logic [71:0] i_data [0:N-1];
    logic [1:0]  i_rdy  [0:N-1];
    logic [1:0]  i_rdyE [0:N-1];
    logic        o_stb  [0:M-1];
    logic        o_sof  [0:M-1];
    logic [71:0] o_data [0:M-1];
    logic [1:0]  o_rdy  [0:M-1];
    logic [1:0]  o_rdyE [0:M-1];
    logic        ff_err;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [71:0] cap_w [0:63];
    logic        cap_s [0:63];
    int          cap_n;
    int          cap_first;
    int          cnt;

    typedef struct {
        logic [2:0]  stb;
        logic [2:0]  sof;
        logic [71:0] d0, d1, d2;
        logic [1:0]  x_stb;
        logic [1:0]  x_sof;
        logic [71:0] x_d0, x_d1;
    } vec_t;
    vec_t vt [$];

    rbus_xbarnxm #(
        .N(N), .M(M), .DEPTH(32), .DST_LSB(56), .LEN_LSB(60), .CLS_BIT(70)
    ) dut (
        .clk(clk), .rst(rst),
        .i_stb(i_stb), .i_sof(i_sof), .i_data(i_data),
        .i_rdy(i_rdy), .i_rdyE(i_rdyE),
        .o_stb(o_stb), .o_sof(o_sof), .o_data(o_data),
        .o_rdy(o_rdy), .o_rdyE(o_rdyE),
        .ff_err(ff_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] hdr(input int dst, input int len, input int cls, input int tag);
        logic [71:0] w;
        w = '0;
        w[70]    = cls[0];
        w[63:60] = len[3:0];
        w[59:56] = dst[3:0];
        w[15:0]  = tag[15:0];
        return w;
    endfunction

    function automatic logic [71:0] dat(input int tag);
        logic [71:0] w;
        w = '0;
        w[71:64] = 8'hA5;
        w[15:0]  = tag[15:0];
        return w;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic v(input logic [2:0] stb, input logic [2:0] sof,
                     input logic [71:0] d0, input logic [71:0] d1, input logic [71:0] d2,
                     input logic [1:0] xs, input logic [1:0] xf,
                     input logic [71:0] x0, input logic [71:0] x1);
        vec_t e;
        e.stb = stb; e.sof = sof; e.d0 = d0; e.d1 = d1; e.d2 = d2;
        e.x_stb = xs; e.x_sof = xf; e.x_d0 = x0; e.x_d1 = x1;
        vt.push_back(e);
    endtask

    task automatic clear_in();
        @(negedge clk);
        for (int n = 0; n < N; n++) begin
            i_stb[n] = 1'b0; i_sof[n] = 1'b0; i_data[n] = '0;
        end
    endtask

    task automatic drive(input int lane, input logic s, input logic [71:0] d);
        @(negedge clk);
        for (int n = 0; n < N; n++) begin
            i_stb[n] = 1'b0; i_sof[n] = 1'b0; i_data[n] = '0;
        end
        i_stb[lane] = 1'b1; i_sof[lane] = s; i_data[lane] = d;
    endtask

    // Returns at the negedge after the last word has been sampled.
    task automatic send_pkt(input int lane, input logic [71:0] h, input int ndata, input int tag);
        drive(lane, 1'b1, h);
        for (int i = 1; i <= ndata; i++) drive(lane, 1'b0, dat(tag + i));
        clear_in();
    endtask

    task automatic collect(input int m, input int limit);
        bit seen;
        seen = 1'b0; cap_n = 0; cap_first = 0;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk); #1;
            if (o_stb[m]) begin
                if (!seen) cap_first = c;
                seen = 1'b1;
                if (cap_n < 64) begin
                    cap_w[cap_n] = o_data[m];
                    cap_s[cap_n] = o_sof[m];
                end
                cap_n++;
            end else if (seen) begin
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        logic [71:0] Z;
        Z = '0;
        for (int n = 0; n < N; n++) begin
            i_stb[n] = 1'b0; i_sof[n] = 1'b0; i_data[n] = '0;
        end
        for (int m = 0; m < M; m++) begin
            o_rdy[m] = 2'b11; o_rdyE[m] = 2'b00;
        end

        // Single packet: in0 -> out1, header + 3 data words; header 2 edges after last word.
        v(3'b001, 3'b001, hdr(1,3,0,'h10), Z, Z, 2'b00, 2'b00, Z, Z);
        v(3'b001, 3'b000, dat('h11), Z, Z, 2'b00, 2'b00, Z, Z);
        v(3'b001, 3'b000, dat('h12), Z, Z, 2'b00, 2'b00, Z, Z);
        v(3'b001, 3'b000, dat('h13), Z, Z, 2'b00, 2'b00, Z, Z);
        v(3'b000, 3'b000, Z, Z, Z, 2'b00, 2'b00, Z, Z);
        v(3'b000, 3'b000, Z, Z, Z, 2'b10, 2'b10, Z, hdr(1,3,0,'h10));
        v(3'b000, 3'b000, Z, Z, Z, 2'b10, 2'b00, Z, dat('h11));
        v(3'b000, 3'b000, Z, Z, Z, 2'b10, 2'b00, Z, dat('h12));
        v(3'b000, 3'b000, Z, Z, Z, 2'b10, 2'b00, Z, dat('h13));
        v(3'b000, 3'b000, Z, Z, Z, 2'b00, 2'b00, Z, Z);
        // Contention: all three lanes send 2-word packets to out0 together.
        v(3'b111, 3'b111, hdr(0,1,0,'h20), hdr(0,1,0,'h30), hdr(0,1,0,'h40), 2'b00, 2'b00, Z, Z);
        v(3'b111, 3'b000, dat('h21), dat('h31), dat('h41), 2'b00, 2'b00, Z, Z);
        v(3'b000, 3'b000, Z, Z, Z, 2'b00, 2'b00, Z, Z);
        v(3'b000, 3'b000, Z, Z, Z, 2'b01, 2'b01, hdr(0,1,0,'h20), Z);
        v(3'b000, 3'b000, Z, Z, Z, 2'b01, 2'b00, dat('h21), Z);
        v(3'b000, 3'b000, Z, Z, Z, 2'b00, 2'b00, Z, Z);
        v(3'b000, 3'b000, Z, Z, Z, 2'b01, 2'b01, hdr(0,1,0,'h30), Z);
        v(3'b000, 3'b000, Z, Z, Z, 2'b01, 2'b00, dat('h31), Z);
        v(3'b000, 3'b000, Z, Z, Z, 2'b00, 2'b00, Z, Z);
        v(3'b000, 3'b000, Z, Z, Z, 2'b01, 2'b01, hdr(0,1,0,'h40), Z);
        v(3'b000, 3'b000, Z, Z, Z, 2'b01, 2'b00, dat('h41), Z);
        v(3'b000, 3'b000, Z, Z, Z, 2'b00, 2'b00, Z, Z);

        repeat (2) @(posedge clk);
        #1;
        check("reset o_stb", {70'b0, o_stb[1], o_stb[0]}, 72'd0);
        check("reset o_data0", o_data[0], 72'd0);
        check("reset ff_err", {71'b0, ff_err}, 72'd0);
        check("reset i_rdy", {66'b0, i_rdy[2], i_rdy[1], i_rdy[0]}, {66'b0, 6'b111111});
        check("reset i_rdyE", {66'b0, i_rdyE[2], i_rdyE[1], i_rdyE[0]}, {66'b0, 6'b111111});
        @(negedge clk); rst = 1'b0;

        for (int k = 0; k < vt.size(); k++) begin
            @(negedge clk);
            for (int n = 0; n < N; n++) begin
                i_stb[n] = vt[k].stb[n];
                i_sof[n] = vt[k].sof[n];
            end
            i_data[0] = vt[k].d0; i_data[1] = vt[k].d1; i_data[2] = vt[k].d2;
            @(posedge clk); #1;
            check($sformatf("v%0d o_stb", k), {70'b0, o_stb[1], o_stb[0]}, {70'b0, vt[k].x_stb});
            check($sformatf("v%0d o_sof", k), {70'b0, o_sof[1], o_sof[0]}, {70'b0, vt[k].x_sof});
            check($sformatf("v%0d o_data0", k), o_data[0], vt[k].x_d0);
            check($sformatf("v%0d o_data1", k), o_data[1], vt[k].x_d1);
            check($sformatf("v%0d ff_err", k), {71'b0, ff_err}, 72'd0);
        end
        clear_in();

        // in2 queued before in0 while out0 is blocked: in0 still goes first.
        o_rdy[0] = 2'b00;
        send_pkt(2, hdr(0,0,0,'h50), 0, 'h50);
        send_pkt(0, hdr(0,0,0,'h60), 0, 'h60);
        @(negedge clk); o_rdy[0] = 2'b11;
        collect(0, 10);
        check("prio first count", 72'(cap_n), 72'd1);
        check("prio first word", cap_w[0], hdr(0,0,0,'h60));
        collect(0, 10);
        check("prio second word", cap_w[0], hdr(0,0,0,'h50));

        // Class gating: c=1 packet held until o_rdyE[0][1] rises.
        @(negedge clk); o_rdy[0] = 2'b01; o_rdyE[0] = 2'b00;
        send_pkt(1, hdr(0,0,1,'h80), 0, 'h80);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (o_stb[0]) cnt++;
        end
        check("gate held", 72'(cnt), 72'd0);
        @(negedge clk); o_rdyE[0] = 2'b10;
        @(posedge clk); #1;
        check("gate grant cycle o_stb", {71'b0, o_stb[0]}, 72'd0);
        @(posedge clk); #1;
        check("gate launch o_stb", {71'b0, o_stb[0]}, 72'd1);
        check("gate launch data", o_data[0], hdr(0,0,1,'h80));
        @(negedge clk); o_rdy[0] = 2'b11; o_rdyE[0] = 2'b00;

        // Malformed: bad destination, then a truncated packet followed by a good one.
        send_pkt(0, hdr(3,2,0,'h90), 2, 'h90);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (o_stb[0] || o_stb[1]) cnt++;
        end
        check("bad dst dropped", 72'(cnt), 72'd0);
        check("bad dst ff_err", {71'b0, ff_err}, 72'd1);
        check("bad dst fifo empty", {70'b0, i_rdyE[0]}, {70'b0, 2'b11});
        drive(0, 1'b1, hdr(1,4,0,'hA0));
        drive(0, 1'b0, dat('hA1));
        send_pkt(0, hdr(1,1,0,'hB0), 1, 'hB0);
        collect(1, 12);
        check("resync count", 72'(cap_n), 72'd2);
        check("resync header", cap_w[0], hdr(1,1,0,'hB0));
        check("resync sof", {71'b0, cap_s[0]}, 72'd1);
        check("resync data", cap_w[1], dat('hB1));
        check("resync ff_err", {71'b0, ff_err}, 72'd1);

        // Full/space boundary on in2 with out0 blocked.
        pulse_reset();
        check("post reset ff_err", {71'b0, ff_err}, 72'd0);
        o_rdy[0] = 2'b00;
        for (int w = 0; w < 32; w++) begin
            drive(2, (w % 16) == 0, ((w % 16) == 0) ? hdr(0,15,0,'h100 + w) : dat('h100 + w));
            @(posedge clk); #1;
            if (w == 15) check("space after 16", {70'b0, i_rdy[2]}, {70'b0, 2'b11});
            if (w == 16) check("space after 17", {70'b0, i_rdy[2]}, {70'b0, 2'b00});
        end
        clear_in();
        check("full no err", {71'b0, ff_err}, 72'd0);
        drive(2, 1'b1, hdr(0,0,0,'h199));
        @(posedge clk); #1;
        check("overflow ff_err", {71'b0, ff_err}, 72'd1);
        clear_in();
        o_rdy[0] = 2'b11;
        cnt = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (o_stb[0]) cnt++;
        end
        check("drain count", 72'(cnt), 72'd32);
        check("drain empty", {70'b0, i_rdyE[2]}, {70'b0, 2'b11});

        // Reset during the second output word.
        send_pkt(0, hdr(1,3,0,'hC0), 3, 'hC0);
        cnt = 0;
        for (int c = 0; c < 10 && cnt == 0; c++) begin
            @(posedge clk); #1;
            if (o_stb[1]) cnt = 1;
        end
        check("rst-mid header seen", 72'(cnt), 72'd1);
        @(posedge clk); #1;
        check("rst-mid word2 o_stb", {71'b0, o_stb[1]}, 72'd1);
        check("rst-mid word2 data", o_data[1], dat('hC1));
        #2 rst = 1'b1;
        #1;
        check("rst-mid o_stb async", {71'b0, o_stb[1]}, 72'd0);
        check("rst-mid i_rdy", {70'b0, i_rdy[0]}, {70'b0, 2'b11});
        check("rst-mid ff_err", {71'b0, ff_err}, 72'd0);
        @(negedge clk); rst = 1'b0;
        send_pkt(1, hdr(1,1,0,'hD0), 1, 'hD0);
        collect(1, 10);
        check("fresh count", 72'(cap_n), 72'd2);
        check("fresh latency", 72'(cap_first), 72'd2);
        check("fresh header", cap_w[0], hdr(1,1,0,'hD0));
        check("fresh data", cap_w[1], dat('hD1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
